posit_divsqrt_arbiter: RTL and testbench

- Shares one posit_divsqrt datapath among NUM_REQ requesters (e.g. per-lane or per-hart issue ports) in the PPU.
- Round-robin arbitration, one operation in flight at a time.
- Captures the granted request into issue registers, drives the unit's handshake, registers the result, and returns it with the originating requester id.
- Sits between requester issue logic and a single posit_divsqrt instance.

---
 rtl/posit_pkg.sv | 57 +++++
 rtl/rr_arbiter_ptr.sv | 31 +++
 rtl/posit_divsqrt_arbiter.sv | 148 ++++++++++++++
 tb/tb_posit_divsqrt_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit types: formats, operation/rounding enums, status flags and
// the divsqrt arbiter state and request types.
package posit_pkg;

    typedef enum logic [1:0] {
        POSIT16_ES1 = 2'd0,
        POSIT8_ES0  = 2'd1,
        POSIT32_ES2 = 2'd2
    } posit_format_e;

    localparam int unsigned POSIT_MAX_WIDTH = 32;

    function automatic int unsigned posit_width(posit_format_e fmt);
        case (fmt)
            POSIT8_ES0:  return 8;
            POSIT32_ES2: return 32;
            default:     return 16;
        endcase
    endfunction

    typedef enum logic {
        DIV  = 1'b0,
        SQRT = 1'b1
    } operation_e;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } roundmode_e;

    // nv is bit 4, dz bit 3
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } divsqrt_arb_state_e;

    // Format-independent view of one request, sized for the widest format
    typedef struct packed {
        logic [1:0][POSIT_MAX_WIDTH-1:0] operands;
        operation_e                      op;
        roundmode_e                      rnd;
        logic                            tag;
    } divsqrt_req_t;

endpackage

// File: rtl/rr_arbiter_ptr.sv
// Round-robin grant: first valid requester at or after the pointer, wrapping.
module rr_arbiter_ptr #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     gnt_idx_o,
    output logic               gnt_any_o
);

    int unsigned idx;

    // Scan from the pointer position and keep the first valid hit
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr_i) + i) % NUM_REQ;
            if (!gnt_any_o && valid_i[IDW'(idx)]) begin
                gnt_any_o          = 1'b1;
                gnt_idx_o          = IDW'(idx);
                gnt_o[IDW'(idx)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/posit_divsqrt_arbiter.sv
// Shares one posit divsqrt datapath among NUM_REQ requesters, one operation
// in flight, round-robin arbitration, result returned with requester id.
module posit_divsqrt_arbiter
    import posit_pkg::*;
#(
    parameter  posit_format_e pFormat = posit_format_e'(0),
    parameter  int unsigned   NUM_REQ = 4,
    localparam int unsigned   WIDTH   = posit_width(pFormat),
    localparam int unsigned   IDW     = $clog2(NUM_REQ)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ-1:0][1:0][WIDTH-1:0] req_operands_i,
    input  operation_e [NUM_REQ-1:0]           req_op_i,
    input  roundmode_e [NUM_REQ-1:0]           req_rnd_i,
    input  logic [NUM_REQ-1:0]                 req_tag_i,
    output logic                               resp_valid_o,
    input  logic                               resp_ready_i,
    output logic [IDW-1:0]                     resp_id_o,
    output logic [WIDTH-1:0]                   resp_result_o,
    output status_t                            resp_status_o,
    output logic                               resp_tag_o,
    output logic                               du_valid_o,
    input  logic                               du_ready_i,
    output logic [1:0][WIDTH-1:0]              du_operands_o,
    output operation_e                         du_op_o,
    output roundmode_e                         du_rnd_o,
    output logic                               du_tag_o,
    output logic                               du_flush_o,
    input  logic                               du_valid_i,
    output logic                               du_ready_o,
    input  logic [WIDTH-1:0]                   du_result_i,
    input  status_t                            du_status_i,
    input  logic                               du_tag_i,
    output logic                               busy_o
);

    // Issue register holds exactly WIDTH-bit operands for this instance
    typedef struct packed {
        logic [1:0][WIDTH-1:0] operands;
        operation_e            op;
        roundmode_e            rnd;
        logic                  tag;
    } issue_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        status_t          status;
        logic             tag;
    } result_t;

    divsqrt_arb_state_e state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    issue_t             issue_q, issue_d;
    result_t            res_q, res_d;

    logic [NUM_REQ-1:0] gnt_oh;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_any;

    rr_arbiter_ptr #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid_i   (req_valid_i),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    // Next-state, capture and grant logic; flush overrides the case result
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        issue_d     = issue_q;
        res_d       = res_q;
        req_ready_o = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_any && !flush_i && !rst_i) begin
                    req_ready_o      = gnt_oh;
                    issue_d.operands = req_operands_i[gnt_idx];
                    issue_d.op       = req_op_i[gnt_idx];
                    issue_d.rnd      = req_rnd_i[gnt_idx];
                    issue_d.tag      = req_tag_i[gnt_idx];
                    id_d             = gnt_idx;
                    rr_ptr_d         = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDW'(1);
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                if (du_valid_i && du_ready_i) begin
                    res_d   = '{result: du_result_i, status: du_status_i, tag: du_tag_i};
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            issue_d = '0;
            res_d   = '0;
            id_d    = '0;
        end
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            issue_q  <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            issue_q  <= issue_d;
            res_q    <= res_d;
        end
    end

    assign du_valid_o    = (state_q == ISSUE);
    assign du_ready_o    = (state_q == ISSUE);
    assign du_operands_o = issue_q.operands;
    assign du_op_o       = issue_q.op;
    assign du_rnd_o      = issue_q.rnd;
    assign du_tag_o      = issue_q.tag;
    assign du_flush_o    = flush_i;

    assign resp_valid_o  = (state_q == RESP);
    assign resp_id_o     = id_q;
    assign resp_result_o = res_q.result;
    assign resp_status_o = res_q.status;
    assign resp_tag_o    = res_q.tag;

    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_posit_divsqrt_arbiter.sv
// Scoreboard bench: requester queues feed the DUT, a round-robin model
// predicts grants and pushes expected responses, a monitor pops and checks.
module tb_posit_divsqrt_arbiter;
    import posit_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned IDW     = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                               rst_i = 1'b1, flush_i = 1'b0;
    logic [NUM_REQ-1:0]                 req_valid = '0;
    logic [NUM_REQ-1:0]                 req_ready_o;
    logic [NUM_REQ-1:0][1:0][WIDTH-1:0] req_ops = '0;
    operation_e [NUM_REQ-1:0]           req_op;
    roundmode_e [NUM_REQ-1:0]           req_rnd;
    logic [NUM_REQ-1:0]                 req_tag = '0;
    logic                               resp_valid_o, resp_ready_i = 1'b0;
    logic [IDW-1:0]                     resp_id_o;
    logic [WIDTH-1:0]                   resp_result_o;
    status_t                            resp_status_o;
    logic                               resp_tag_o;
    logic                               du_valid_o, du_ready_i = 1'b0;
    logic [1:0][WIDTH-1:0]              du_operands_o;
    operation_e                         du_op_o;
    roundmode_e                         du_rnd_o;
    logic                               du_tag_o, du_flush_o;
    logic                               du_valid_i, du_ready_o;
    logic [WIDTH-1:0]                   du_result_i;
    status_t                            du_status_i;
    logic                               du_tag_i;
    logic                               busy_o;

    posit_divsqrt_arbiter #(.pFormat(POSIT16_ES1), .NUM_REQ(NUM_REQ)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_operands_i(req_ops), .req_op_i(req_op), .req_rnd_i(req_rnd), .req_tag_i(req_tag),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
        .resp_result_o(resp_result_o), .resp_status_o(resp_status_o), .resp_tag_o(resp_tag_o),
        .du_valid_o(du_valid_o), .du_ready_i(du_ready_i), .du_operands_o(du_operands_o),
        .du_op_o(du_op_o), .du_rnd_o(du_rnd_o), .du_tag_o(du_tag_o), .du_flush_o(du_flush_o),
        .du_valid_i(du_valid_i), .du_ready_o(du_ready_o), .du_result_i(du_result_i),
        .du_status_i(du_status_i), .du_tag_i(du_tag_i), .busy_o(busy_o)
    );

    // Stand-in datapath: fixed answers for the directed cases, a mixing
    // function elsewhere so operand/op/rnd routing errors change the result
    function automatic logic [20:0] dp_fn(logic [15:0] a, logic [15:0] b, operation_e op, roundmode_e rnd);
        if (op == DIV) begin
            if (b == 16'h0000) return {16'h8000, 5'b01000};
            if (b == 16'h4000) return {a, 5'b00000};
            return {a ^ {b[7:0], b[15:8]} ^ {13'b0, rnd}, {3'b000, a[15] & b[15], ^(a ^ b)}};
        end
        if (a == 16'h6000) return {16'h5000, 5'b00000};
        if (a[15]) return {16'h8000, 5'b10000};
        return {{1'b0, a[15:1]} ^ {13'b0, rnd}, {4'b0000, a[0]}};
    endfunction

    logic        dv_en = 1'b0, stray = 1'b0;
    logic [20:0] dp_out;
    assign dp_out      = dp_fn(du_operands_o[0], du_operands_o[1], du_op_o, du_rnd_o);
    assign du_result_i = dp_out[20:5];
    assign du_status_i = status_t'(dp_out[4:0]);
    assign du_tag_i    = du_tag_o;
    assign du_valid_i  = (du_valid_o & dv_en) | stray;

    typedef struct {
        logic [15:0] a, b;
        operation_e  op;
        roundmode_e  rnd;
        logic        tag;
    } op_t;

    typedef struct {
        int unsigned id;
        logic [15:0] result;
        logic [4:0]  status;
        logic        tag;
        int          grant_cyc;
        bit          fast;
        bit          seen;
    } exp_t;

    op_t  pend[NUM_REQ][$];
    exp_t sb[$];

    int          n_cmp = 0, n_fail = 0, cyc = 0;
    bit          model_busy = 1'b0;
    int unsigned model_ptr = 0;
    bit          rst_req = 1'b1, flush_req = 1'b0, rst_now = 1'b0, flush_now = 1'b0;
    bit          check_rst_next = 1'b0, fast_mode = 1'b0, stray_en = 1'b0;
    int          dr_mode = 0, dv_mode = 0, rr_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic fail_timeout(string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s @cyc %0d: got timeout expected completion", nm, cyc);
    endtask

    function automatic logic pick(int m);
        if (m == 0) return 1'b1;
        if (m == 2) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic op_t mk(logic [15:0] a, logic [15:0] b, operation_e op);
        op_t o;
        o.a = a; o.b = b; o.op = op; o.rnd = RNE; o.tag = 1'b1;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a   = 16'($urandom);
        o.b   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        o.op  = operation_e'($urandom_range(0, 1));
        o.rnd = roundmode_e'($urandom_range(0, 4));
        o.tag = 1'($urandom_range(0, 1));
        return o;
    endfunction

    // One clock: drive inputs after the edge, then predict and check grant
    task automatic cycle();
        int g;
        exp_t e;
        logic [20:0] r;
        @(posedge clk);
        #1;
        rst_i   = rst_req;
        flush_i = flush_req;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i].size() > 0) begin
                req_valid[i]  = 1'b1;
                req_ops[i][0] = pend[i][0].a;
                req_ops[i][1] = pend[i][0].b;
                req_op[i]     = pend[i][0].op;
                req_rnd[i]    = pend[i][0].rnd;
                req_tag[i]    = pend[i][0].tag;
            end else begin
                req_valid[i]  = 1'b0;
                req_ops[i][0] = 16'($urandom);
                req_ops[i][1] = 16'($urandom);
                req_op[i]     = operation_e'($urandom_range(0, 1));
                req_rnd[i]    = roundmode_e'($urandom_range(0, 4));
                req_tag[i]    = 1'($urandom_range(0, 1));
            end
        end
        du_ready_i   = pick(dr_mode);
        dv_en        = pick(dv_mode);
        stray        = stray_en && ($urandom_range(0, 7) == 0);
        resp_ready_i = rst_req ? 1'b0 : pick(rr_mode);
        #2;
        if (check_rst_next) begin
            check("rst_resp_valid", 32'(resp_valid_o), 0);
            check("rst_du_valid", 32'(du_valid_o), 0);
            check("rst_du_ready", 32'(du_ready_o), 0);
            check("rst_resp_result", 32'(resp_result_o), 0);
            check("rst_resp_id", 32'(resp_id_o), 0);
            check("rst_resp_status", 32'(resp_status_o), 0);
            check("rst_resp_tag", 32'(resp_tag_o), 0);
            check("rst_du_operands", 32'(du_operands_o), 0);
            check_rst_next = 1'b0;
        end
        if (rst_req) begin
            check("req_ready_in_reset", 32'(req_ready_o), 0);
            model_ptr = 0;
        end else begin
            g = -1;
            if (!model_busy && !flush_req) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int idx;
                    idx = int'((model_ptr + k) % NUM_REQ);
                    if (g < 0 && pend[idx].size() > 0) g = idx;
                end
            end
            check("req_ready", 32'(req_ready_o), (g >= 0) ? (32'd1 << g) : 32'd0);
            check("busy", 32'(busy_o), 32'(model_busy));
            if (g >= 0) begin
                r = dp_fn(pend[g][0].a, pend[g][0].b, pend[g][0].op, pend[g][0].rnd);
                e.id = g; e.result = r[20:5]; e.status = r[4:0]; e.tag = pend[g][0].tag;
                e.grant_cyc = cyc; e.fast = fast_mode; e.seen = 1'b0;
                sb.push_back(e);
                void'(pend[g].pop_front());
                model_ptr  = (g + 1) % NUM_REQ;
                model_busy = 1'b1;
            end
        end
        flush_now = flush_req;
        rst_now   = rst_req;
        flush_req = 1'b0;
        rst_req   = 1'b0;
    endtask

    // Monitor: every response presented is compared with the queue head
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_i && resp_valid_o) begin
                if (sb.size() == 0) begin
                    check("resp_spurious", 32'(resp_valid_o), 0);
                end else begin
                    check("resp_id", 32'(resp_id_o), sb[0].id);
                    check("resp_result", 32'(resp_result_o), 32'(sb[0].result));
                    check("resp_status", 32'(resp_status_o), 32'(sb[0].status));
                    check("resp_tag", 32'(resp_tag_o), 32'(sb[0].tag));
                    if (!sb[0].seen) begin
                        if (sb[0].fast) check("latency", 32'(cyc - sb[0].grant_cyc), 2);
                        else check("latency_min", 32'(cyc - sb[0].grant_cyc >= 2), 1);
                        sb[0].seen = 1'b1;
                    end
                    if (resp_ready_i) begin
                        void'(sb.pop_front());
                        model_busy = 1'b0;
                    end
                end
            end
            if (flush_now || rst_now) begin
                sb.delete();
                model_busy = 1'b0;
                flush_now  = 1'b0;
                rst_now    = 1'b0;
            end
        end
    end

    task automatic wait_idle(string nm, int max);
        for (int k = 0; k < max; k++) begin
            bit empty;
            empty = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) if (pend[i].size() > 0) empty = 1'b0;
            if (!model_busy && empty) return;
            cycle();
        end
        fail_timeout(nm);
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        cycle();
        check_rst_next = 1'b1;
        cycle();
    endtask

    initial begin
        fast_mode = 1'b1;
        do_reset();

        // single divide 2.0 / 1.0
        pend[0].push_back(mk(16'h5000, 16'h4000, DIV));
        wait_idle("single_div", 20);

        // contention from a fresh pointer
        do_reset();
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < NUM_REQ; i++) pend[i].push_back(rand_op());
        wait_idle("contention", 60);

        // backpressure on the response, sqrt(4.0)
        rr_mode = 2;
        pend[3].push_back(mk(16'h6000, 16'h1234, SQRT));
        cycle();
        pend[0].push_back(mk(16'h3000, 16'h4000, DIV));
        for (int k = 0; k < 7; k++) cycle();
        rr_mode = 0;
        wait_idle("backpressure", 20);

        // divide by zero
        pend[1].push_back(mk(16'h4000, 16'h0000, DIV));
        wait_idle("div_zero", 20);

        // flush while the datapath stalls
        dr_mode = 2;
        pend[2].push_back(rand_op());
        cycle();
        flush_req = 1'b1;
        cycle();
        cycle();
        dr_mode = 0;
        for (int i = 0; i < NUM_REQ; i++) pend[i].push_back(rand_op());
        wait_idle("after_flush", 40);

        // reset while holding a response
        rr_mode = 2;
        pend[1].push_back(rand_op());
        for (int k = 0; k < 4; k++) cycle();
        rr_mode = 0;
        do_reset();
        pend[2].push_back(rand_op());
        wait_idle("after_reset", 20);

        // randomized traffic with stalls, stray valids and flushes
        fast_mode = 1'b0;
        dr_mode = 1; dv_mode = 1; rr_mode = 1; stray_en = 1'b1;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (pend[i].size() < 3 && $urandom_range(0, 3) == 0) pend[i].push_back(rand_op());
            flush_req = ($urandom_range(0, 39) == 0);
            cycle();
        end
        wait_idle("drain", 3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
